ofifo_col: RTL

- Output FIFO between the MAC array column outputs and the post-processing (ReLU) stage.
- Each array column pushes partial sums independently, so columns arrive skewed in time.
- The block buffers each column separately and presents a full row only when every column has data.
- The downstream stage pops one aligned row per read.

---
 rtl/ofifo_col.sv | 82 ++++++++
 1 files changed

// File: rtl/ofifo_col.sv
// Column-skew output FIFO: per-lane queues, a row pops only when all lanes hold data.
// Optional sticky protocol-error flag enabled by OFIFO_COL_ERR_EN.
module ofifo_col #(
    parameter int bw    = 16,
    parameter int col   = 8,
    parameter int depth = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [col-1:0]      wr,
    input  logic [bw*col-1:0]   in,
    input  logic                rd,
    output logic [bw*col-1:0]   out,
    output logic                o_valid,
    output logic                o_full,
    output logic                ready,
    output logic                err
);
    localparam int aw = $clog2(depth);

    logic [col-1:0] nonempty;
    logic [col-1:0] full;
    logic           pop;

    assign o_valid = &nonempty;
    assign o_full  = |full;
    assign ready   = ~o_full;
    assign pop     = rd & o_valid;

    for (genvar i = 0; i < col; i++) begin : g_lane
        logic [bw-1:0] mem [depth];
        logic [aw-1:0] wptr;
        logic [aw-1:0] rptr;
        logic [aw:0]   cnt;
        logic [bw-1:0] q;
        logic          push;

        assign full[i]     = (cnt == (aw+1)'(depth));
        assign nonempty[i] = (cnt != '0);
        assign push        = wr[i] & ~full[i];
        assign out[bw*i +: bw] = q;

        // Storage needs no reset; only pointers and counts define contents.
        always_ff @(posedge clk) begin
            if (push)
                mem[wptr] <= in[bw*i +: bw];
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                wptr <= '0;
                rptr <= '0;
                cnt  <= '0;
                q    <= '0;
            end else begin
                if (push)
                    wptr <= wptr + 1'b1;
                if (pop) begin
                    rptr <= rptr + 1'b1;
                    q    <= mem[rptr];
                end
                unique case ({push, pop})
                    2'b10:   cnt <= cnt + 1'b1;
                    2'b01:   cnt <= cnt - 1'b1;
                    default: cnt <= cnt;
                endcase
            end
        end
    end

`ifdef OFIFO_COL_ERR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err <= 1'b0;
        else if ((|(wr & full)) | (rd & ~o_valid))
            err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule
